// File: rtl/cfeb_jtag_seq.sv
// Sequences multi-chunk JTAG shifts through the CFEB JTAG engine: each chunk
// is a shift command followed by a readback command, with strobe/ack handshakes.
module cfeb_jtag_seq #(
  parameter int TMO_CYC = 1023,
  parameter int GAP_CYC = 2
) (
  input  logic        FASTCLK,
  input  logic        RST,
  input  logic        GO,
  input  logic        INSTR,
  input  logic        HEAD,
  input  logic        TAIL,
  input  logic [9:0]  NBITS,
  input  logic [15:0] WD_DATA,
  input  logic        WD_VALID,
  output logic        WD_READY,
  output logic [15:0] RD_DATA,
  output logic        RD_VALID,
  input  logic        RD_READY,
  output logic        JT_STROBE,
  output logic [9:0]  JT_COMMAND,
  output logic [15:0] JT_INDATA,
  input  logic        JT_ACK,
  input  logic [15:0] JT_OUTDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int TMAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SH_STB = 3'd2,
    SH_REL = 3'd3,
    RB_STB = 3'd4,
    RB_REL = 3'd5,
    PUSH   = 3'd6,
    GAP    = 3'd7
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tmo_q;
  logic [9:0]    rem_q;
  logic          first_q;
  logic          instr_q;
  logic          head_q;
  logic          tail_q;
  logic          wd_ready_q;
  logic          rd_valid_q;
  logic          jt_strobe_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [9:0]    jt_command_q;
  logic [15:0]   jt_indata_q;
  logic [15:0]   rd_data_q;

  logic          last_s;
  logic          wait_s;
  logic          tmo_hit_s;
  logic          gap_ok_s;
  logic [3:0]    cnt_m1_s;
  logic [9:0]    rem_d;
  logic [9:0]    shift_cmd_d;

  // Chunk sizing, shift-command encoding and timeout/gap qualifiers
  always_comb begin
    last_s      = (rem_q <= 10'd16);
    cnt_m1_s    = last_s ? (rem_q[3:0] - 4'd1) : 4'hF;
    rem_d       = last_s ? 10'd0 : (rem_q - 10'd16);
    shift_cmd_d = {cnt_m1_s, 3'b000, instr_q, last_s & tail_q, first_q & head_q};
    wait_s      = (state_q == SH_STB) || (state_q == SH_REL) ||
                  (state_q == RB_STB) || (state_q == RB_REL);
    tmo_hit_s   = wait_s && (tmo_q == TW'(TMO_CYC));
    gap_ok_s    = (tmo_q >= TW'(GAP_CYC));
  end

  // Sequencer FSM; the strobe rises one cycle after command/data are loaded
  always_ff @(posedge FASTCLK) begin
    if (RST) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      rem_q        <= 10'd0;
      first_q      <= 1'b0;
      instr_q      <= 1'b0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      wd_ready_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      jt_strobe_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      jt_command_q <= 10'd0;
      jt_indata_q  <= 16'd0;
      rd_data_q    <= 16'd0;
    end else begin
      done_q <= 1'b0;
      tmo_q  <= wait_s ? (tmo_q + TW'(1)) : '0;
      if (tmo_hit_s) begin
        err_q       <= 1'b1;
        jt_strobe_q <= 1'b0;
        rem_q       <= 10'd0;
        busy_q      <= 1'b0;
        tmo_q       <= '0;
        state_q     <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (GO) begin
              if (NBITS == 10'd0) begin
                err_q <= 1'b1;
              end else begin
                err_q      <= 1'b0;
                rem_q      <= NBITS;
                first_q    <= 1'b1;
                instr_q    <= INSTR;
                head_q     <= HEAD;
                tail_q     <= TAIL;
                wd_ready_q <= 1'b1;
                busy_q     <= 1'b1;
                state_q    <= FETCH;
              end
            end
          end
          FETCH: begin
            if (WD_VALID && wd_ready_q) begin
              wd_ready_q   <= 1'b0;
              jt_indata_q  <= WD_DATA;
              jt_command_q <= shift_cmd_d;
              rem_q        <= rem_d;
              first_q      <= 1'b0;
              state_q      <= SH_STB;
            end
          end
          SH_STB: begin
            if (!jt_strobe_q) begin
              jt_strobe_q <= 1'b1;
            end else if (JT_ACK) begin
              jt_strobe_q <= 1'b0;
              tmo_q       <= '0;
              state_q     <= SH_REL;
            end
          end
          SH_REL: begin
            if (!JT_ACK && gap_ok_s) begin
              jt_command_q <= 10'd5;
              tmo_q        <= '0;
              state_q      <= RB_STB;
            end
          end
          // The readback ack is withheld until the shift finishes in the engine
          RB_STB: begin
            if (!jt_strobe_q) begin
              jt_strobe_q <= 1'b1;
            end else if (JT_ACK) begin
              rd_data_q   <= JT_OUTDATA;
              jt_strobe_q <= 1'b0;
              tmo_q       <= '0;
              state_q     <= RB_REL;
            end
          end
          RB_REL: begin
            if (!JT_ACK && gap_ok_s) begin
              rd_valid_q <= 1'b1;
              tmo_q      <= '0;
              state_q    <= PUSH;
            end
          end
          PUSH: begin
            if (RD_READY && rd_valid_q) begin
              rd_valid_q <= 1'b0;
              if (rem_q != 10'd0) begin
                wd_ready_q <= 1'b1;
                state_q    <= FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= GAP;
              end
            end
          end
          GAP: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign WD_READY   = wd_ready_q;
  assign RD_DATA    = rd_data_q;
  assign RD_VALID   = rd_valid_q;
  assign JT_STROBE  = jt_strobe_q;
  assign JT_COMMAND = jt_command_q;
  assign JT_INDATA  = jt_indata_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule
